// File: rtl/crit_path_select_driver_pkg.sv
// crit_path_pkg: FSM state and grant encodings plus the qualifier-true pattern shared by the selector driver files
package crit_path_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE_A = 2'd1, DRIVE_B = 2'd2} drive_state_t;
  typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_t;
  localparam logic [2:0] QUAL_TRUE = 3'b111;
endpackage

// File: rtl/crit_path_select_driver_if.sv
// crit_path_select_driver_if: source A/B valid-ready-data, selector terms, busy and counters; master = driver, slave = sources/selector side
interface crit_path_select_driver_if #(parameter int CNT_W = 8);
  logic a_valid, a_data, a_ready;
  logic b_valid, b_data, b_ready;
  logic in1, in2, non_critical;
  logic critical, additional_condition1, additional_condition2;
  logic busy;
  logic [CNT_W-1:0] a_count, b_count;
  modport master (
    input  a_valid, a_data, b_valid, b_data,
    output a_ready, b_ready, in1, in2, non_critical, critical,
           additional_condition1, additional_condition2, busy, a_count, b_count
  );
  modport slave (
    output a_valid, a_data, b_valid, b_data,
    input  a_ready, b_ready, in1, in2, non_critical, critical,
           additional_condition1, additional_condition2, busy, a_count, b_count
  );
endinterface

// File: rtl/crit_path_select_driver_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; i_req[0]=A, i_req[1]=B, i_en gates grants, i_last_grant breaks ties, o_gnt one-hot
module rr_arb2
  import crit_path_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_en,
  input  grant_t     i_last_grant,
  output logic [1:0] o_gnt
);
  assign o_gnt[0] = i_en & i_req[0] & (~i_req[1] | (i_last_grant == GRANT_B));
  assign o_gnt[1] = i_en & i_req[1] & (~i_req[0] | (i_last_grant == GRANT_A));
endmodule

// File: rtl/crit_path_select_driver.sv
// crit_path_select_driver: arbitrates sources A/B and encodes each word onto the qualified selector, then holds it; ports clk, rst (sync, active high), bus (master: handshakes in, selector terms/busy/counters out)
module crit_path_select_driver
  import crit_path_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input logic clk,
  input logic rst,
  crit_path_select_driver_if.master bus
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  drive_state_t r_state, w_state;
  grant_t r_grant, w_grant;
  logic [HW-1:0] r_hold, w_hold;
  logic r_word, w_word, r_last, w_last;
  logic [CNT_W-1:0] r_a_cnt, r_b_cnt;
  logic [1:0] w_gnt;
  logic [5:0] r_out, w_out;
  logic r_busy, w_busy;
  rr_arb2 u_arb (
    .i_req       ({bus.b_valid, bus.a_valid}),
    .i_en        (r_state == IDLE),
    .i_last_grant(r_grant),
    .o_gnt       (w_gnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= GRANT_B;
      r_hold  <= '0;
      r_word  <= 1'b0;
      r_last  <= 1'b0;
      r_a_cnt <= '0;
      r_b_cnt <= '0;
      r_out   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_hold  <= w_hold;
      r_word  <= w_word;
      r_last  <= w_last;
      r_a_cnt <= r_a_cnt + CNT_W'(w_gnt[0]);
      r_b_cnt <= r_b_cnt + CNT_W'(w_gnt[1]);
      r_out   <= w_out;
      r_busy  <= w_busy;
    end
  end
  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_hold  = r_hold;
    w_word  = r_word;
    w_last  = r_last;
    if (r_state == IDLE) begin
      if (|w_gnt) begin
        w_state = w_gnt[0] ? DRIVE_A : DRIVE_B;
        w_grant = w_gnt[0] ? GRANT_A : GRANT_B;
        w_word  = w_gnt[0] ? bus.a_data : bus.b_data;
        w_hold  = HW'(HOLD_CYCLES - 1);
      end
    end else if (r_hold == '0) begin
      w_state = IDLE;
      w_last  = r_word;
    end else begin
      w_hold = r_hold - HW'(1);
    end
  end
  // {in1, in2, non_critical, critical, additional_condition1, additional_condition2}, taken from next-state so the register stage lines up with the FSM
  always_comb begin
    w_out  = (w_state == DRIVE_A) ? {w_word, w_last, 1'b1, QUAL_TRUE} :
             (w_state == DRIVE_B) ? {w_last, w_word, 4'b0000} : {w_last, w_last, 4'b0000};
    w_busy = w_state != IDLE;
  end
  assign bus.a_ready = w_gnt[0];
  assign bus.b_ready = w_gnt[1];
  assign {bus.in1, bus.in2, bus.non_critical, bus.critical,
          bus.additional_condition1, bus.additional_condition2} = r_out;
  assign bus.busy    = r_busy;
  assign bus.a_count = r_a_cnt;
  assign bus.b_count = r_b_cnt;
endmodule

// File: tb/tb_crit_path_select_driver.sv
// tb_crit_path_select_driver: directed stimulus with a scoreboard queue checked by a negedge monitor and a modelled selector register
module tb_crit_path_select_driver;
  localparam int HOLD = 2;
  localparam int CW   = 2;
  typedef struct {
    bit src_b;
    bit word;
    logic [CW-1:0] ac;
    logic [CW-1:0] bc;
  } item_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel_q = 1'b0;
  int total = 0;
  int bad = 0;
  item_t sb[$];
  item_t cur;
  logic [CW-1:0] ea = '0, eb = '0;
  bit rst_pend = 1'b1, prev_busy = 1'b0, mon_last = 1'b0;
  int blen = 0;
  logic [5:0] outs6, exp6;
  crit_path_select_driver_if #(.CNT_W(CW)) bus ();
  crit_path_select_driver #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    sel_q <= (bus.critical & bus.additional_condition1 & bus.additional_condition2) ?
             (bus.non_critical ? bus.in1 : bus.in2) : bus.in2;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push(input bit src_b, input bit d);
    if (src_b) eb++;
    else ea++;
    sb.push_back('{src_b, d, ea, eb});
  endtask
  task automatic send(input bit src_b, input bit d);
    bit got = 1'b0;
    push(src_b, d);
    if (src_b) begin
      bus.b_valid = 1'b1;
      bus.b_data  = d;
    end else begin
      bus.a_valid = 1'b1;
      bus.a_data  = d;
    end
    for (int n = 0; n < 40 && !got; n++) begin
      #1 got = src_b ? bus.b_ready : bus.a_ready;
      @(posedge clk);
    end
    #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout: got no ready expected ready within 40 cycles");
    end
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    outs6 = {bus.in1, bus.in2, bus.non_critical, bus.critical,
             bus.additional_condition1, bus.additional_condition2};
    if (rst_pend) begin
      chk("reset_outs", {outs6, bus.busy}, 0);
      chk("reset_counts", {bus.a_count, bus.b_count}, 0);
      mon_last  = 1'b0;
      prev_busy = 1'b0;
      blen      = 0;
    end else begin
      if (bus.busy && !prev_busy) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_xfer: got busy expected no transfer");
        end else begin
          cur = sb.pop_front();
          chk("counts", {bus.a_count, bus.b_count}, {cur.ac, cur.bc});
        end
      end
      if (bus.busy) begin
        blen++;
        exp6 = cur.src_b ? {mon_last, cur.word, 4'b0000} : {cur.word, mon_last, 4'b1111};
        if (blen == HOLD) chk("sel_out_drive", sel_q, cur.word);
        chk("drive_outs", outs6, exp6);
      end else begin
        if (prev_busy) begin
          chk("hold_len", blen, HOLD);
          mon_last = cur.word;
          blen     = 0;
        end
        exp6 = {mon_last, mon_last, 4'b0000};
        chk("idle_outs", outs6, exp6);
        chk("sel_out_idle", sel_q, mon_last);
      end
      prev_busy = bus.busy;
    end
    rst_pend = rst;
  end
  initial begin
    int hs;
    int cyc;
    bus.a_valid = 1'b0;
    bus.a_data  = 1'b0;
    bus.b_valid = 1'b0;
    bus.b_data  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    send(1'b0, 1'b1);
    repeat (20) @(negedge clk);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    repeat (6) @(negedge clk);
    push(1'b0, 1'b1);
    push(1'b1, 1'b0);
    push(1'b0, 1'b1);
    push(1'b1, 1'b0);
    bus.a_valid = 1'b1;
    bus.a_data  = 1'b1;
    bus.b_valid = 1'b1;
    bus.b_data  = 1'b0;
    hs  = 0;
    cyc = 0;
    while (hs < 4 && cyc < 40) begin
      #1 hs += int'((bus.a_valid & bus.a_ready) | (bus.b_valid & bus.b_ready));
      @(posedge clk);
      cyc++;
    end
    #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    chk("rr_throughput", cyc, 3 * (HOLD + 1) + 1);
    repeat (6) @(negedge clk);
    send(1'b0, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ea = '0;
    eb = '0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) send(1'b0, i[0]);
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("queue_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
